// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: store-and-forward SPI transmit channel.
// The host writes a header word whose low byte is the payload word count N,
// then N payload words. Once all N words are buffered they are shifted out
// MSB-first on TX_CLK/TX_DATA, framed by TX_LOAD, with GAP_BITS idle bit
// periods between words. A one-bit-period TX_STOP closes the message.
//
// Line outputs are registered from the FSM state, so the line timeline
// trails the state timeline by one uniform clock cycle. This makes the
// first TX_LOAD rise two cycles after the last payload write. It also means
// the single LOAD cycle between words shows up on the lines as one cycle
// with TX_CLK high and TX_LOAD low.
//
// Write-side handshake: ENA is a one-cycle strobe with no back-pressure.
// Words are accepted in IDLE (header) and COLLECT (payload). An ENA seen in
// LOAD, SHIFT, GAP or STOP is dropped and flagged by a one-cycle OVERRUN.
// BUSY tells the upstream controller to stop routing words here.
module spi_tx_serializer #(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_BITS    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        ENA,
    output logic        TX_CLK,
    output logic        TX_DATA,
    output logic        TX_LOAD,
    output logic        TX_STOP,
    output logic        BUSY,
    output logic        OVERRUN,
    output logic [2:0]  STATE_DBG
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_STOP    = 3'd5;

    localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    logic [15:0] mem [0:254];

    logic [2:0]  state_q,    state_d;
    logic [7:0]  n_q,        n_d;
    logic [7:0]  wr_ptr_q,   wr_ptr_d;
    logic [7:0]  rd_ptr_q,   rd_ptr_d;
    logic [7:0]  wc_q,       wc_d;
    logic [15:0] shift_q,    shift_d;
    logic [3:0]  bit_idx_q,  bit_idx_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic        phase_q,    phase_d;
    logic [3:0]  gap_cnt_q,  gap_cnt_d;
    logic        tx_clk_q,   tx_clk_d;
    logic        tx_data_q,  tx_data_d;
    logic        tx_load_q,  tx_load_d;
    logic        tx_stop_q,  tx_stop_d;
    logic        busy_q,     busy_d;
    logic        overrun_q,  overrun_d;

    logic        wr_en;
    logic        half_end;
    logic        bit_end;
    logic [2:0]  after_word;

    // Next-state logic: message collection, bit sequencing and line values.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wc_d       = wc_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        gap_cnt_d  = gap_cnt_q;
        wr_en      = 1'b0;

        half_end   = (half_cnt_q == HP_LAST);
        bit_end    = half_end && phase_q;
        // wc_q counts words already moved into the shift register.
        after_word = (wc_q != n_q) ? S_LOAD : S_STOP;

        // Shared half-period timer for SHIFT, GAP and STOP. It ends each bit
        // period with phase 0 and count 0, ready for the next state.
        if (state_q == S_SHIFT || state_q == S_GAP || state_q == S_STOP) begin
            if (half_end) begin
                half_cnt_d = 8'd0;
                phase_d    = ~phase_q;
            end else begin
                half_cnt_d = half_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // A zero-length header is discarded without side effects.
                if (ENA && (DATA[7:0] != 8'd0)) begin
                    n_d      = DATA[7:0];
                    wr_ptr_d = 8'd0;
                    rd_ptr_d = 8'd0;
                    wc_d     = 8'd0;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (ENA) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 8'd1;
                    if ((wr_ptr_q + 8'd1) == n_q) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                shift_d    = mem[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + 8'd1;
                wc_d       = wc_q + 8'd1;
                bit_idx_d  = 4'd15;
                half_cnt_d = 8'd0;
                phase_d    = 1'b0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_end) begin
                    if (bit_idx_q == 4'd0) begin
                        gap_cnt_d = 4'd0;
                        state_d   = (GAP_BITS > 0) ? S_GAP : after_word;
                    end else begin
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_idx_d = bit_idx_q - 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = after_word;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line values derived from the current state, registered below.
    always_comb begin
        tx_clk_d  = 1'b1;
        tx_data_d = 1'b0;
        tx_load_d = 1'b0;
        tx_stop_d = 1'b0;
        if (state_q == S_SHIFT) begin
            tx_clk_d  = phase_q;
            tx_data_d = shift_q[15];
            tx_load_d = 1'b1;
        end else if (state_q == S_STOP) begin
            tx_clk_d  = phase_q;
            tx_stop_d = 1'b1;
        end
        // BUSY rises with the accepted header and falls together with TX_STOP.
        busy_d    = (state_d != S_IDLE) || (state_q == S_STOP);
        overrun_d = ENA && (state_q == S_LOAD || state_q == S_SHIFT ||
                            state_q == S_GAP  || state_q == S_STOP);
    end

    // State and output registers; reset aborts any message in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            n_q        <= 8'd0;
            wr_ptr_q   <= 8'd0;
            rd_ptr_q   <= 8'd0;
            wc_q       <= 8'd0;
            shift_q    <= 16'd0;
            bit_idx_q  <= 4'd0;
            half_cnt_q <= 8'd0;
            phase_q    <= 1'b0;
            gap_cnt_q  <= 4'd0;
            tx_clk_q   <= 1'b1;
            tx_data_q  <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_stop_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wc_q       <= wc_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_clk_q   <= tx_clk_d;
            tx_data_q  <= tx_data_d;
            tx_load_q  <= tx_load_d;
            tx_stop_q  <= tx_stop_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Message buffer write port; contents need no reset since the pointers do.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= DATA;
        end
    end

    assign TX_CLK    = tx_clk_q;
    assign TX_DATA   = tx_data_q;
    assign TX_LOAD   = tx_load_q;
    assign TX_STOP   = tx_stop_q;
    assign BUSY      = busy_q;
    assign OVERRUN   = overrun_q;
    assign STATE_DBG = state_q;

endmodule
